// File: rtl/altivec_apu_issue_if.sv
// Issue/completion channel between the AltiVec APU front end and the vector unit.
// Bit vectors use big-endian [0:N] numbering to match the PowerPC instruction fields.
interface altivec_apu_issue_if;
    logic        vu_issue_valid;
    logic        vu_issue_ready;
    logic [0:31] vu_issue_ins;
    logic [0:31] vu_issue_ra;
    logic [0:31] vu_issue_rb;
    logic        vu_done;
    logic [0:3]  vu_cr6;

    // Front end side: drives the issue request and receives completion.
    modport master (
        output vu_issue_valid,
        output vu_issue_ins,
        output vu_issue_ra,
        output vu_issue_rb,
        input  vu_issue_ready,
        input  vu_done,
        input  vu_cr6
    );

    // Vector unit side.
    modport slave (
        input  vu_issue_valid,
        input  vu_issue_ins,
        input  vu_issue_ra,
        input  vu_issue_rb,
        output vu_issue_ready,
        output vu_done,
        output vu_cr6
    );
endinterface

// File: rtl/altivec_apu_issue.sv
// AltiVec front end downstream of the p405 APU shell: decodes the DCD instruction,
// tracks the accepted op through EXE, captures GPR operands, issues it to the vector
// unit and, for record-form compares, waits for completion and holds CR6.
module altivec_apu_issue #(
    parameter int TO_W = 8
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [0:31] APU_AltiVec_Ins,
    input  logic        APU_AltiVec_DcdHold,
    input  logic [0:31] APU_AltiVec_RaData,
    input  logic [0:31] APU_AltiVec_RbData,
    input  logic        APU_AltiVec_ExeFlush,
    output logic        AltiVec_APU_ValidOp,
    output logic        AltiVec_APU_RaEn,
    output logic        AltiVec_APU_RbEn,
    output logic        AltiVec_APU_CR6En,
    output logic        AltiVec_APU_ExeBusy,
    output logic [0:3]  AltiVec_APU_CRData,
    altivec_apu_issue_if.master vu,
    output logic        vu_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXE   = 2'd1,
        S_ISSUE = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    // WAIT lasts at most CNT_MAX cycles before the watchdog gives up.
    localparam logic [TO_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [0:31]       ins_q, ins_d;
    logic [0:31]       ra_q, ra_d;
    logic [0:31]       rb_q, rb_d;
    logic              cmp_q, cmp_d;
    logic [0:3]        cr_q, cr_d;
    logic              to_q, to_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]   cnt_nxt;

    logic              op4;
    logic              dec_cmp;
    logic              dec_gpr;

    // Raw decode of the DCD instruction: primary opcode 4, vcmp* with Rc=1, GPR-to-vector move.
    always_comb begin
        op4     = (APU_AltiVec_Ins[0:5] == 6'd4);
        dec_cmp = op4 & APU_AltiVec_Ins[21] & (APU_AltiVec_Ins[26:31] == 6'b000110);
        dec_gpr = op4 & (APU_AltiVec_Ins[21:31] == 11'h7FE);
    end

    // Decode outputs to the shell are forced low while reset is asserted.
    always_comb begin
        AltiVec_APU_ValidOp = rst_b & op4;
        AltiVec_APU_CR6En   = rst_b & dec_cmp;
        AltiVec_APU_RaEn    = rst_b & dec_gpr;
        AltiVec_APU_RbEn    = rst_b & dec_gpr;
    end

    // Next-state and datapath update for the accept/EXE/issue/wait sequence.
    always_comb begin
        state_d = state_q;
        ins_d   = ins_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        cmp_d   = cmp_q;
        cr_d    = cr_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        cnt_nxt = cnt_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                // Only IDLE accepts; elsewhere the core is held off by ExeBusy.
                if (op4 && !APU_AltiVec_DcdHold) begin
                    ins_d   = APU_AltiVec_Ins;
                    cmp_d   = dec_cmp;
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                ra_d    = APU_AltiVec_RaData;
                rb_d    = APU_AltiVec_RbData;
                state_d = APU_AltiVec_ExeFlush ? S_IDLE : S_ISSUE;
            end
            S_ISSUE: begin
                // The op is past the flush point; only the VU handshake moves us on.
                if (vu.vu_issue_ready) begin
                    if (cmp_q) begin
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                // Completion takes priority over a watchdog expiry in the same cycle.
                if (vu.vu_done) begin
                    cr_d    = vu.vu_cr6;
                    state_d = S_IDLE;
                end else if (cnt_nxt == CNT_MAX) begin
                    cr_d    = 4'b0000;
                    to_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_nxt;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured operands, cleared asynchronously by rst_b.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            ins_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            cmp_q   <= 1'b0;
            cr_q    <= 4'b0000;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ins_q   <= ins_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            cmp_q   <= cmp_d;
            cr_q    <= cr_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs derived directly from registered state so reset drops them at once.
    always_comb begin
        AltiVec_APU_ExeBusy = (state_q != S_IDLE);
        AltiVec_APU_CRData  = cr_q;
        vu.vu_issue_valid   = (state_q == S_ISSUE);
        vu.vu_issue_ins     = ins_q;
        vu.vu_issue_ra      = ra_q;
        vu.vu_issue_rb      = rb_q;
        vu_timeout          = to_q;
    end

endmodule

// File: tb/tb_altivec_apu_issue.sv
// Directed bench for altivec_apu_issue (watchdog shortened to TO_W=4).
module tb_altivec_apu_issue;
    logic        clk;
    logic        rst_b;
    logic [31:0] ins;
    logic        dcd_hold;
    logic [31:0] ra_data;
    logic [31:0] rb_data;
    logic        exe_flush;
    logic        valid_op, ra_en, rb_en, cr6_en, exe_busy;
    logic [3:0]  cr_data;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    altivec_apu_issue_if vif();

    altivec_apu_issue #(.TO_W(4)) dut (
        .clk                  (clk),
        .rst_b                (rst_b),
        .APU_AltiVec_Ins      (ins),
        .APU_AltiVec_DcdHold  (dcd_hold),
        .APU_AltiVec_RaData   (ra_data),
        .APU_AltiVec_RbData   (rb_data),
        .APU_AltiVec_ExeFlush (exe_flush),
        .AltiVec_APU_ValidOp  (valid_op),
        .AltiVec_APU_RaEn     (ra_en),
        .AltiVec_APU_RbEn     (rb_en),
        .AltiVec_APU_CR6En    (cr6_en),
        .AltiVec_APU_ExeBusy  (exe_busy),
        .AltiVec_APU_CRData   (cr_data),
        .vu                   (vif),
        .vu_timeout           (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; ins = 32'h10000406; dcd_hold = 1'b0; exe_flush = 1'b0;
        ra_data = '0; rb_data = '0;
        vif.vu_issue_ready = 1'b0; vif.vu_done = 1'b0; vif.vu_cr6 = 4'b0000;
        #12;
        total++; if (valid_op !== 1'b0) begin bad++; $display("FAIL rst_validop got=%b exp=0", valid_op); end
        total++; if (cr6_en !== 1'b0) begin bad++; $display("FAIL rst_cr6en got=%b exp=0", cr6_en); end
        total++; if (exe_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", exe_busy); end
        total++; if (cr_data !== 4'b0000) begin bad++; $display("FAIL rst_crdata got=%b exp=0000", cr_data); end
        total++; if (vif.vu_issue_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", vif.vu_issue_valid); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
        ins = 32'h0;
        tick();
        rst_b = 1'b1;
        tick();
    endtask

    task automatic test_noncmp();
        ins = 32'h10000000; vif.vu_issue_ready = 1'b1;
        #1;
        total++; if (valid_op !== 1'b1) begin bad++; $display("FAIL add_validop got=%b exp=1", valid_op); end
        total++; if (cr6_en !== 1'b0) begin bad++; $display("FAIL add_cr6en got=%b exp=0", cr6_en); end
        total++; if (ra_en !== 1'b0) begin bad++; $display("FAIL add_raen got=%b exp=0", ra_en); end
        tick(); ins = 32'h0;
        total++; if (exe_busy !== 1'b1) begin bad++; $display("FAIL add_busy_exe got=%b exp=1", exe_busy); end
        total++; if (vif.vu_issue_valid !== 1'b0) begin bad++; $display("FAIL add_valid_exe got=%b exp=0", vif.vu_issue_valid); end
        tick();
        total++; if (vif.vu_issue_valid !== 1'b1) begin bad++; $display("FAIL add_valid_issue got=%b exp=1", vif.vu_issue_valid); end
        total++; if (vif.vu_issue_ins !== 32'h10000000) begin bad++; $display("FAIL add_ins got=%h exp=10000000", vif.vu_issue_ins); end
        total++; if (exe_busy !== 1'b1) begin bad++; $display("FAIL add_busy_issue got=%b exp=1", exe_busy); end
        tick();
        total++; if (vif.vu_issue_valid !== 1'b0) begin bad++; $display("FAIL add_valid_end got=%b exp=0", vif.vu_issue_valid); end
        total++; if (exe_busy !== 1'b0) begin bad++; $display("FAIL add_busy_end got=%b exp=0", exe_busy); end
    endtask

    // Accepts a compare and walks it to the first WAIT cycle.
    task automatic start_cmp();
        ins = 32'h10000406; vif.vu_issue_ready = 1'b1;
        tick(); ins = 32'h0;
        tick();
        tick();
    endtask

    task automatic test_compare();
        ins = 32'h10000406;
        #1;
        total++; if (cr6_en !== 1'b1) begin bad++; $display("FAIL cmp_cr6en got=%b exp=1", cr6_en); end
        total++; if (valid_op !== 1'b1) begin bad++; $display("FAIL cmp_validop got=%b exp=1", valid_op); end
        start_cmp();
        total++; if (exe_busy !== 1'b1) begin bad++; $display("FAIL cmp_busy_wait got=%b exp=1", exe_busy); end
        total++; if (vif.vu_issue_valid !== 1'b0) begin bad++; $display("FAIL cmp_valid_wait got=%b exp=0", vif.vu_issue_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (exe_busy !== 1'b1) begin bad++; $display("FAIL cmp_busy_%0d got=%b exp=1", i, exe_busy); end
        end
        total++; if (cr_data !== 4'b0000) begin bad++; $display("FAIL cmp_cr_before got=%b exp=0000", cr_data); end
        vif.vu_done = 1'b1; vif.vu_cr6 = 4'b1000;
        tick();
        vif.vu_done = 1'b0; vif.vu_cr6 = 4'b0000;
        total++; if (cr_data !== 4'b1000) begin bad++; $display("FAIL cmp_crdata got=%b exp=1000", cr_data); end
        total++; if (exe_busy !== 1'b0) begin bad++; $display("FAIL cmp_busy_done got=%b exp=0", exe_busy); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL cmp_timeout got=%b exp=0", timeout); end
        // completion pulse while idle must not touch CR6
        vif.vu_done = 1'b1; vif.vu_cr6 = 4'b1111;
        tick();
        vif.vu_done = 1'b0; vif.vu_cr6 = 4'b0000;
        total++; if (cr_data !== 4'b1000) begin bad++; $display("FAIL idle_done_ignored got=%b exp=1000", cr_data); end
    endtask

    task automatic test_gpr_move();
        ins = 32'h100007FE; vif.vu_issue_ready = 1'b0;
        #1;
        total++; if (ra_en !== 1'b1 || rb_en !== 1'b1) begin bad++; $display("FAIL mv_rarben got=%b%b exp=11", ra_en, rb_en); end
        total++; if (cr6_en !== 1'b0) begin bad++; $display("FAIL mv_cr6en got=%b exp=0", cr6_en); end
        tick(); ins = 32'h0; ra_data = 32'h12345678; rb_data = 32'h9ABCDEF0;
        tick(); ra_data = 32'hDEADBEEF; rb_data = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            total++; if (vif.vu_issue_valid !== 1'b1) begin bad++; $display("FAIL mv_valid_%0d got=%b exp=1", i, vif.vu_issue_valid); end
            total++; if (vif.vu_issue_ins !== 32'h100007FE) begin bad++; $display("FAIL mv_ins_%0d got=%h exp=100007fe", i, vif.vu_issue_ins); end
            total++; if (vif.vu_issue_ra !== 32'h12345678) begin bad++; $display("FAIL mv_ra_%0d got=%h exp=12345678", i, vif.vu_issue_ra); end
            total++; if (vif.vu_issue_rb !== 32'h9ABCDEF0) begin bad++; $display("FAIL mv_rb_%0d got=%h exp=9abcdef0", i, vif.vu_issue_rb); end
            if (i < 2) tick();
        end
        vif.vu_issue_ready = 1'b1;
        tick();
        total++; if (vif.vu_issue_valid !== 1'b0) begin bad++; $display("FAIL mv_valid_end got=%b exp=0", vif.vu_issue_valid); end
        total++; if (exe_busy !== 1'b0) begin bad++; $display("FAIL mv_busy_end got=%b exp=0", exe_busy); end
    endtask

    task automatic test_flush_hold();
        ins = 32'h10000000; vif.vu_issue_ready = 1'b1;
        tick(); ins = 32'h0; exe_flush = 1'b1;
        tick(); exe_flush = 1'b0;
        total++; if (exe_busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", exe_busy); end
        total++; if (vif.vu_issue_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", vif.vu_issue_valid); end
        tick();
        total++; if (vif.vu_issue_valid !== 1'b0) begin bad++; $display("FAIL flush_valid2 got=%b exp=0", vif.vu_issue_valid); end
        ins = 32'h10000000; dcd_hold = 1'b1;
        tick();
        total++; if (exe_busy !== 1'b0) begin bad++; $display("FAIL hold_busy got=%b exp=0", exe_busy); end
        tick();
        total++; if (exe_busy !== 1'b0) begin bad++; $display("FAIL hold_busy2 got=%b exp=0", exe_busy); end
        ins = 32'h0; dcd_hold = 1'b0;
    endtask

    task automatic test_done_on_limit();
        start_cmp();
        for (int i = 0; i < 14; i++) tick();
        total++; if (exe_busy !== 1'b1) begin bad++; $display("FAIL lim_busy got=%b exp=1", exe_busy); end
        vif.vu_done = 1'b1; vif.vu_cr6 = 4'b0100;
        tick();
        vif.vu_done = 1'b0; vif.vu_cr6 = 4'b0000;
        total++; if (cr_data !== 4'b0100) begin bad++; $display("FAIL lim_crdata got=%b exp=0100", cr_data); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL lim_timeout got=%b exp=0", timeout); end
        total++; if (exe_busy !== 1'b0) begin bad++; $display("FAIL lim_busy_end got=%b exp=0", exe_busy); end
    endtask

    task automatic test_timeout();
        start_cmp();
        for (int i = 0; i < 14; i++) begin
            total++; if (exe_busy !== 1'b1 || timeout !== 1'b0) begin bad++; $display("FAIL to_early_%0d busy=%b to=%b exp busy=1 to=0", i, exe_busy, timeout); end
            tick();
        end
        total++; if (exe_busy !== 1'b1) begin bad++; $display("FAIL to_busy15 got=%b exp=1", exe_busy); end
        tick();
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_flag got=%b exp=1", timeout); end
        total++; if (cr_data !== 4'b0000) begin bad++; $display("FAIL to_crdata got=%b exp=0000", cr_data); end
        total++; if (exe_busy !== 1'b0) begin bad++; $display("FAIL to_busy_end got=%b exp=0", exe_busy); end
        tick();
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", timeout); end
    endtask

    task automatic test_reset_wait();
        start_cmp();
        vif.vu_done = 1'b1; vif.vu_cr6 = 4'b0010;
        tick();
        vif.vu_done = 1'b0; vif.vu_cr6 = 4'b0000;
        total++; if (cr_data !== 4'b0010) begin bad++; $display("FAIL rw_crdata_pre got=%b exp=0010", cr_data); end
        start_cmp();
        #2;
        rst_b = 1'b0; ins = 32'h7C000000;
        #1;
        total++; if (exe_busy !== 1'b0) begin bad++; $display("FAIL rw_busy got=%b exp=0", exe_busy); end
        total++; if (cr_data !== 4'b0000) begin bad++; $display("FAIL rw_crdata got=%b exp=0000", cr_data); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rw_timeout got=%b exp=0", timeout); end
        total++; if (valid_op !== 1'b0) begin bad++; $display("FAIL rw_validop got=%b exp=0", valid_op); end
        tick();
        rst_b = 1'b1;
        #1;
        total++; if (valid_op !== 1'b0) begin bad++; $display("FAIL rw_validop_7c got=%b exp=0", valid_op); end
        // reset while an issue request is pending drops it
        ins = 32'h10000000; vif.vu_issue_ready = 1'b0;
        tick(); ins = 32'h0;
        tick();
        total++; if (vif.vu_issue_valid !== 1'b1) begin bad++; $display("FAIL ri_valid_pre got=%b exp=1", vif.vu_issue_valid); end
        #2; rst_b = 1'b0; #1;
        total++; if (vif.vu_issue_valid !== 1'b0) begin bad++; $display("FAIL ri_valid got=%b exp=0", vif.vu_issue_valid); end
        total++; if (vif.vu_issue_ins !== 32'h0) begin bad++; $display("FAIL ri_ins got=%h exp=0", vif.vu_issue_ins); end
        tick(); rst_b = 1'b1; tick();
        total++; if (exe_busy !== 1'b0) begin bad++; $display("FAIL ri_busy got=%b exp=0", exe_busy); end
    endtask

    initial begin
        test_reset();
        test_noncmp();
        test_compare();
        test_gpr_move();
        test_flush_hold();
        test_done_on_limit();
        test_timeout();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
